// File: rtl/dm_sized_mem_if.sv
// Bus bundle between the MEM stage and the sized data memory.
// Carries the req/ready/done handshake, request fields and load result.
// Master drives requests and the slave drives ready, done, rdata and err.
interface dm_sized_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
    output ready, done, rdata, err
  );
endinterface

// File: rtl/dm_sized_mem.sv
// Byte-addressed big-endian data memory: byte/half/word loads (sign/zero-extended) and stores.
// Latency: accept at edge N, done pulses in cycle N+WAIT_STATES+2; one access per WAIT_STATES+2 cycles.
// Backpressure: ready low while busy; req is ignored until ready and is accepted in the done cycle.
// Option: define DM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module dm_sized_mem #(
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  dm_sized_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            state;
  logic [3:0]        wcnt;

  // Request fields captured at accept time.
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // Registered outputs.
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  // Array is not touched by rst; contents start at zero.
  logic [7:0]        mem [DEPTH] = '{default: 8'h00};

  logic              is_half;
  logic              is_word;
  logic              range_err;
  logic              fault;
  logic [AW-1:0]     idx_raw;
  logic [AW-1:0]     idx0;
  logic [AW-1:0]     idx1;
  logic [AW-1:0]     idx2;
  logic [AW-1:0]     idx3;
  logic [31:0]       ld_data;

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  // Reserved size 2'b11 behaves as a word access.
  assign is_half   = (size_q == 2'b01);
  assign is_word   = size_q[1];
  assign range_err = |addr_q[ADDR_W-1:AW];
  assign idx_raw   = addr_q[AW-1:0];

`ifdef DM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (is_half & idx_raw[0]) | (is_word & (|idx_raw[1:0]));
  assign fault    = range_err | misalign;
  assign idx0     = idx_raw;
`else
  // Misaligned accesses are silently rounded down to their natural boundary.
  assign fault    = range_err;
  assign idx0     = is_word ? (idx_raw & ~AW'(3)) :
                    is_half ? (idx_raw & ~AW'(1)) : idx_raw;
`endif

  // Follow-on byte indices wrap naturally at the top of the array.
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

  // Assemble the big-endian load value, right-justified and extended.
  always_comb begin
    ld_data = 32'h0;
    case (size_q)
      2'b00: ld_data = uns_q ? {24'h0, mem[idx0]} : {{24{mem[idx0][7]}}, mem[idx0]};
      2'b01: ld_data = uns_q ? {16'h0, mem[idx0], mem[idx1]}
                             : {{16{mem[idx0][7]}}, mem[idx0], mem[idx1]};
      default: ld_data = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
    endcase
  end

  // Handshake FSM with registered ready/done/err/rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (bus.req && ready_q) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            uns_q   <= bus.unsigned_ld;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            ready_q <= 1'b0;
            wcnt    <= 4'd0;
            state   <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'(WAIT_STATES - 1)) begin
            wcnt  <= 4'd0;
            state <= S_ACCESS;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_ACCESS: begin
          done_q  <= 1'b1;
          err_q   <= fault;
          ready_q <= 1'b1;
          if (!we_q) begin
            rdata_q <= fault ? 32'h0 : ld_data;
          end
          state <= S_RESP;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Store commit: only the addressed bytes, only in ACCESS, never on a fault.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && we_q && !fault) begin
      case (size_q)
        2'b00: mem[idx0] <= wdata_q[7:0];
        2'b01: begin
          mem[idx0] <= wdata_q[15:8];
          mem[idx1] <= wdata_q[7:0];
        end
        default: begin
          mem[idx0] <= wdata_q[31:24];
          mem[idx1] <= wdata_q[23:16];
          mem[idx2] <= wdata_q[15:8];
          mem[idx3] <= wdata_q[7:0];
        end
      endcase
    end
  end

endmodule
